// File: rtl/bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// bus_sequencer_if
// External asynchronous-style bus between the CPU bus sequencer (master) and a
// slave device. The slave reply is assumed to be synchronous to the master's
// clock.
//
//   bus_ad    master -> slave  address / write data
//   bus_din   slave  -> master read data
//   bus_sync  master -> slave  address strobe
//   bus_rd    master -> slave  read data strobe
//   bus_wr    master -> slave  write data strobe
//   bus_wtbt  master -> slave  write / byte-cycle indicator
//   bus_rply  slave  -> master reply
// -----------------------------------------------------------------------------
interface bus_sequencer_if;
    logic [15:0] bus_ad;
    logic [15:0] bus_din;
    logic        bus_sync;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_wtbt;
    logic        bus_rply;

    modport master (
        output bus_ad,
        output bus_sync,
        output bus_rd,
        output bus_wr,
        output bus_wtbt,
        input  bus_din,
        input  bus_rply
    );

    modport slave (
        input  bus_ad,
        input  bus_sync,
        input  bus_rd,
        input  bus_wr,
        input  bus_wtbt,
        output bus_din,
        output bus_rply
    );
endinterface

// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
// Runs one external bus cycle per CPU request: address phase (ADDR), data
// phase waiting for the slave reply (DATA), strobe release waiting for the
// reply to drop (RELEASE), and a one-cycle error state (ERR) for timeouts and
// odd word addresses. Everything advances only on ce=1.
//
// Ports
//   clk, reset  clock, asynchronous active-high reset
//   ce          clock enable
//   rd_req      read request  (sampled in IDLE)
//   wr_req      write request (sampled in IDLE, wins over rd_req)
//   byte_op     1 = byte access, 0 = word access
//   addr        CPU address
//   wdata       CPU write data
//   rdata       registered read data
//   done        one-ce-cycle pulse on successful completion
//   bus_err     one-ce-cycle pulse on timeout or odd word address
//   busy        high while not IDLE
//   bus         external bus, master side
// -----------------------------------------------------------------------------
module bus_sequencer #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        byte_op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        bus_err,
    output logic        busy,
    bus_sequencer_if.master bus
);

    // Wide enough to hold TIMEOUT itself, so the counter never wraps.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        RELEASE = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             byte_q, byte_d;
    logic             write_q, write_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [15:0]      ad_q, ad_d;
    logic             sync_q, sync_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             wtbt_q, wtbt_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [15:0]      write_word;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    // Byte writes replicate the low byte on both lanes.
    assign write_word = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

    // Outputs are computed for the state being entered, so every bus output
    // is a flop that reflects the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        write_d = write_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ad_d    = ad_q;
        sync_d  = sync_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wtbt_d  = wtbt_q;

        case (state_q)
            IDLE: begin
                ad_d   = 16'h0000;
                sync_d = 1'b0;
                rd_d   = 1'b0;
                wr_d   = 1'b0;
                wtbt_d = 1'b0;
                // A request still held during the done pulse belongs to the
                // transaction that just finished; take new ones a cycle later.
                if ((rd_req || wr_req) && !done_q) begin
                    wdata_d = wdata;
                    byte_d  = byte_op;
                    write_d = wr_req;
                    if (!byte_op && addr[0]) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ADDR;
                        cnt_d   = '0;
                        // The bus_ad register doubles as the address latch.
                        ad_d    = addr;
                        sync_d  = 1'b1;
                        wtbt_d  = wr_req | byte_op;
                    end
                end
            end

            ADDR: begin
                state_d = DATA;
                ad_d    = write_q ? write_word : 16'h0000;
                sync_d  = 1'b1;
                rd_d    = ~write_q;
                wr_d    = write_q;
                wtbt_d  = byte_q;
            end

            DATA: begin
                // A reply wins even when the counter would reach TIMEOUT now.
                if (bus.bus_rply) begin
                    if (!write_q) begin
                        rdata_d = bus.bus_din;
                    end
                    state_d = RELEASE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (cnt_inc == TIMEOUT_C) begin
                    cnt_d   = cnt_inc;
                    state_d = ERR;
                    err_d   = 1'b1;
                    ad_d    = 16'h0000;
                    sync_d  = 1'b0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    wtbt_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RELEASE: begin
                if (!bus.bus_rply) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ad_d    = 16'h0000;
                    sync_d  = 1'b0;
                    wtbt_d  = 1'b0;
                end
            end

            ERR: begin
                state_d = IDLE;
                ad_d    = 16'h0000;
                sync_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                wtbt_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                ad_d    = 16'h0000;
                sync_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                wtbt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wdata_q <= 16'h0000;
            byte_q  <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= 16'h0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ad_q    <= 16'h0000;
            sync_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wtbt_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ad_q    <= ad_d;
            sync_q  <= sync_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wtbt_q  <= wtbt_d;
        end
    end

    assign rdata        = rdata_q;
    assign done         = done_q;
    assign bus_err      = err_q;
    assign busy         = (state_q != IDLE);
    assign bus.bus_ad   = ad_q;
    assign bus.bus_sync = sync_q;
    assign bus.bus_rd   = rd_q;
    assign bus.bus_wr   = wr_q;
    assign bus.bus_wtbt = wtbt_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
// Drives CPU requests and plays a synchronous slave; results are compared
// against a transaction-level model of the sequencer's timing and data rules.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;
    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        reset, ce, rd_req, wr_req, byte_op;
    logic [15:0] addr, wdata, rdata;
    logic        done, bus_err, busy;

    bus_sequencer_if bus_if();

    bus_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .byte_op (byte_op),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .bus_err (bus_err),
        .busy    (busy),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] rdata_model;

    // Model expectations
    bit          exp_ok, exp_sync;
    int          exp_n;
    logic [15:0] exp_ad_addr, exp_ad_data, exp_rdata;
    logic        exp_wtbt_a, exp_wtbt_d;

    // Observations of one transaction
    int          obs_n, obs_done_cnt, obs_err_cnt;
    bit          obs_sync_seen, obs_wtbt_any, obs_rd_seen, obs_wr_seen, obs_data_seen;
    bit          obs_addr_seen, obs_err_strobes, obs_freeze_bad, obs_hung;
    logic [15:0] obs_ad_addr, obs_ad_data, obs_ad_err, obs_ad_after;
    logic        obs_wtbt_addr, obs_wtbt_data;
    bit          obs_pulse_after, obs_busy_after, obs_sync_after, obs_sync_after2;

    // Transaction-level reference: counts in ce cycles from the accepting edge.
    // Success: ADDR, DATA for (reply+1) cycles, RELEASE, then done -> 4+reply.
    // Timeout: DATA is entered at cycle 2 and aborts TIMEOUT cycles later.
    // Odd word address: error in the cycle right after acceptance.
    task automatic model_txn(input logic t_wr, input logic t_byte,
                             input logic [15:0] t_addr, input logic [15:0] t_wdata,
                             input logic [15:0] t_din, input int t_reply);
        exp_ad_addr = t_addr;
        exp_wtbt_a  = t_wr | t_byte;
        exp_wtbt_d  = t_byte;
        exp_ad_data = t_byte ? {t_wdata[7:0], t_wdata[7:0]} : t_wdata;
        if (!t_byte && t_addr[0]) begin
            exp_sync = 1'b0;
            exp_ok   = 1'b0;
            exp_n    = 1;
        end else begin
            exp_sync = 1'b1;
            if (t_reply >= 0 && t_reply < TIMEOUT) begin
                exp_ok = 1'b1;
                exp_n  = 4 + t_reply;
            end else begin
                exp_ok = 1'b0;
                exp_n  = 2 + TIMEOUT;
            end
        end
        exp_rdata = (exp_ok && !t_wr) ? t_din : rdata_model;
    endtask

    task automatic run_txn(input logic t_rd, input logic t_wr, input logic t_byte,
                           input logic [15:0] t_addr, input logic [15:0] t_wdata,
                           input logic [15:0] t_din, input int t_reply,
                           input bit rand_ce, input bit scramble, input bit hold);
        bit          adv;
        int          n, idx, guard;
        logic [38:0] snap, prev_snap;
        n = 0; idx = 0; guard = 0;
        obs_n = 0; obs_done_cnt = 0; obs_err_cnt = 0;
        obs_sync_seen = 0; obs_wtbt_any = 0; obs_rd_seen = 0; obs_wr_seen = 0;
        obs_data_seen = 0; obs_addr_seen = 0; obs_err_strobes = 0;
        obs_freeze_bad = 0; obs_hung = 0;
        obs_ad_addr = 16'hxxxx; obs_ad_data = 16'hxxxx; obs_ad_err = 16'h0000;
        obs_wtbt_addr = 1'bx; obs_wtbt_data = 1'bx; obs_sync_after2 = 0;
        rd_req = t_rd; wr_req = t_wr; byte_op = t_byte;
        addr = t_addr; wdata = t_wdata;
        bus_if.bus_din = t_din; bus_if.bus_rply = 1'b0;
        prev_snap = {done, bus_err, busy, rdata, bus_if.bus_ad, bus_if.bus_sync,
                     bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_wtbt};
        while (obs_done_cnt + obs_err_cnt == 0 && guard < 500) begin
            adv = ce;
            @(posedge clk); #1;
            guard++;
            snap = {done, bus_err, busy, rdata, bus_if.bus_ad, bus_if.bus_sync,
                    bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_wtbt};
            if (!adv && snap !== prev_snap) obs_freeze_bad = 1;
            prev_snap = snap;
            ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (adv) begin
                n++;
                if (bus_if.bus_sync) obs_sync_seen = 1;
                if (bus_if.bus_wtbt) obs_wtbt_any = 1;
                if (bus_if.bus_sync && !bus_if.bus_rd && !bus_if.bus_wr && !obs_data_seen
                    && !obs_addr_seen) begin
                    obs_addr_seen = 1;
                    obs_ad_addr   = bus_if.bus_ad;
                    obs_wtbt_addr = bus_if.bus_wtbt;
                end
                if (bus_if.bus_rd || bus_if.bus_wr) begin
                    if (!obs_data_seen) begin
                        obs_ad_data   = bus_if.bus_ad;
                        obs_wtbt_data = bus_if.bus_wtbt;
                    end
                    obs_data_seen = 1;
                    if (bus_if.bus_rd) obs_rd_seen = 1;
                    if (bus_if.bus_wr) obs_wr_seen = 1;
                    if (idx == t_reply) bus_if.bus_rply = 1'b1;
                    idx++;
                end else if (bus_if.bus_sync && obs_data_seen) begin
                    bus_if.bus_rply = 1'b0;
                end
                if (done) begin
                    obs_done_cnt++;
                    obs_n = n;
                end
                if (bus_err) begin
                    obs_err_cnt++;
                    obs_n = n;
                    obs_err_strobes = bus_if.bus_sync | bus_if.bus_rd | bus_if.bus_wr | bus_if.bus_wtbt;
                    obs_ad_err = bus_if.bus_ad;
                end
                if ((done || bus_err) && !hold) begin
                    rd_req = 1'b0; wr_req = 1'b0;
                end
                if (scramble && busy) begin
                    addr = 16'($urandom); wdata = 16'($urandom); byte_op = 1'($urandom);
                end
            end
        end
        if (guard >= 500) obs_hung = 1;
        ce = 1'b1;
        @(posedge clk); #1;
        obs_pulse_after = done | bus_err;
        obs_busy_after  = busy;
        obs_sync_after  = bus_if.bus_sync;
        obs_ad_after    = bus_if.bus_ad;
        if (hold) begin
            @(posedge clk); #1;
            obs_sync_after2 = bus_if.bus_sync;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        bus_if.bus_rply = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rdata_model = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; rd_req = 1'b0; wr_req = 1'b0; byte_op = 1'b0;
        addr = 16'h0000; wdata = 16'h0000;
        bus_if.bus_din = 16'h0000; bus_if.bus_rply = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        checks++;
        if ({done, bus_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got done/err/busy=%b expected 000", {done, bus_err, busy}); end
        checks++;
        if ({bus_if.bus_sync, bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_wtbt} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000",
                               {bus_if.bus_sync, bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_wtbt});
        end
        checks++;
        if (bus_if.bus_ad !== 16'h0000) begin errors++; $display("FAIL reset_bus_ad: got %h expected 0000", bus_if.bus_ad); end
        reset = 1'b0; ce = 1'b1;
        rdata_model = 16'h0000;
        $display("txn reset");
    endtask

    task automatic test_word_read();
        model_txn(1'b0, 1'b0, 16'o177660, 16'h0000, 16'o123456, 2);
        run_txn(1'b1, 1'b0, 1'b0, 16'o177660, 16'h0000, 16'o123456, 2, 1'b0, 1'b0, 1'b0);
        $display("txn word_read addr=%o n=%0d rdata=%o", 16'o177660, obs_n, rdata);
        checks++;
        if (obs_done_cnt !== 1 || obs_err_cnt !== 0) begin errors++; $display("FAIL word_read_done: got done=%0d err=%0d expected 1/0", obs_done_cnt, obs_err_cnt); end
        checks++;
        if (obs_n !== exp_n) begin errors++; $display("FAIL word_read_latency: got %0d expected %0d", obs_n, exp_n); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL word_read_rdata: got %o expected %o", rdata, exp_rdata); end
        checks++;
        if (obs_wtbt_any !== 1'b0) begin errors++; $display("FAIL word_read_wtbt: got wtbt seen=%0d expected 0", obs_wtbt_any); end
        checks++;
        if (obs_ad_addr !== exp_ad_addr) begin errors++; $display("FAIL word_read_addr: got %o expected %o", obs_ad_addr, exp_ad_addr); end
        checks++;
        if (!(obs_rd_seen && !obs_wr_seen)) begin errors++; $display("FAIL word_read_dir: got rd=%0d wr=%0d expected 1/0", obs_rd_seen, obs_wr_seen); end
        checks++;
        if (obs_pulse_after !== 1'b0 || obs_ad_after !== 16'h0000) begin
            errors++; $display("FAIL word_read_idle: got pulse=%0d bus_ad=%h expected 0/0000", obs_pulse_after, obs_ad_after);
        end
        rdata_model = exp_rdata;
    endtask

    task automatic test_byte_write();
        model_txn(1'b1, 1'b1, 16'o001001, 16'o000252, 16'h5555, 0);
        run_txn(1'b0, 1'b1, 1'b1, 16'o001001, 16'o000252, 16'h5555, 0, 1'b0, 1'b0, 1'b0);
        $display("txn byte_write addr=%o n=%0d ad_data=%h", 16'o001001, obs_n, obs_ad_data);
        checks++;
        if (obs_ad_addr !== exp_ad_addr) begin errors++; $display("FAIL byte_write_addr: got %o expected %o", obs_ad_addr, exp_ad_addr); end
        checks++;
        if (obs_ad_data !== exp_ad_data) begin errors++; $display("FAIL byte_write_data: got %h expected %h", obs_ad_data, exp_ad_data); end
        checks++;
        if (obs_wtbt_addr !== exp_wtbt_a || obs_wtbt_data !== exp_wtbt_d) begin
            errors++; $display("FAIL byte_write_wtbt: got %b/%b expected %b/%b", obs_wtbt_addr, obs_wtbt_data, exp_wtbt_a, exp_wtbt_d);
        end
        checks++;
        if (obs_done_cnt !== 1 || obs_n !== exp_n) begin errors++; $display("FAIL byte_write_done: got done=%0d n=%0d expected 1/%0d", obs_done_cnt, obs_n, exp_n); end
        checks++;
        if (rdata !== rdata_model) begin errors++; $display("FAIL byte_write_rdata: got %h expected %h", rdata, rdata_model); end
    endtask

    task automatic test_odd_addr();
        model_txn(1'b1, 1'b0, 16'o001001, 16'h1234, 16'h0000, 0);
        run_txn(1'b0, 1'b1, 1'b0, 16'o001001, 16'h1234, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        $display("txn odd_addr addr=%o n=%0d err=%0d", 16'o001001, obs_n, obs_err_cnt);
        checks++;
        if (obs_err_cnt !== 1 || obs_done_cnt !== 0) begin errors++; $display("FAIL odd_addr_err: got err=%0d done=%0d expected 1/0", obs_err_cnt, obs_done_cnt); end
        checks++;
        if (obs_n !== exp_n) begin errors++; $display("FAIL odd_addr_latency: got %0d expected %0d", obs_n, exp_n); end
        checks++;
        if (obs_sync_seen !== exp_sync) begin errors++; $display("FAIL odd_addr_sync: got %0d expected %0d", obs_sync_seen, exp_sync); end
        checks++;
        if (obs_err_strobes !== 1'b0 || obs_pulse_after !== 1'b0) begin
            errors++; $display("FAIL odd_addr_strobes: got strobes=%0d pulse_after=%0d expected 0/0", obs_err_strobes, obs_pulse_after);
        end
    endtask

    task automatic test_timeout();
        model_txn(1'b0, 1'b0, 16'o000100, 16'h0000, 16'hBEEF, -1);
        run_txn(1'b1, 1'b0, 1'b0, 16'o000100, 16'h0000, 16'hBEEF, -1, 1'b0, 1'b0, 1'b0);
        $display("txn timeout n=%0d err=%0d", obs_n, obs_err_cnt);
        checks++;
        if (obs_err_cnt !== 1 || obs_done_cnt !== 0) begin errors++; $display("FAIL timeout_err: got err=%0d done=%0d expected 1/0", obs_err_cnt, obs_done_cnt); end
        checks++;
        if (obs_n !== exp_n) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", obs_n, exp_n); end
        checks++;
        if (obs_err_strobes !== 1'b0 || obs_ad_err !== 16'h0000) begin
            errors++; $display("FAIL timeout_strobes: got strobes=%0d bus_ad=%h expected 0/0000", obs_err_strobes, obs_ad_err);
        end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL timeout_rdata: got %h expected %h", rdata, exp_rdata); end
        // Reply in the very cycle the counter reaches TIMEOUT still succeeds.
        model_txn(1'b0, 1'b0, 16'o000102, 16'h0000, 16'h0F0F, TIMEOUT - 1);
        run_txn(1'b1, 1'b0, 1'b0, 16'o000102, 16'h0000, 16'h0F0F, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        $display("txn late_reply n=%0d done=%0d", obs_n, obs_done_cnt);
        checks++;
        if (obs_done_cnt !== 1 || obs_err_cnt !== 0 || obs_n !== exp_n) begin
            errors++; $display("FAIL late_reply: got done=%0d err=%0d n=%0d expected 1/0/%0d", obs_done_cnt, obs_err_cnt, obs_n, exp_n);
        end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL late_reply_rdata: got %h expected %h", rdata, exp_rdata); end
        rdata_model = exp_rdata;
    endtask

    task automatic test_both_req_ce();
        model_txn(1'b1, 1'b0, 16'o002000, 16'hA5C3, 16'h7777, 1);
        run_txn(1'b1, 1'b1, 1'b0, 16'o002000, 16'hA5C3, 16'h7777, 1, 1'b1, 1'b0, 1'b0);
        $display("txn both_req_ce n=%0d wr=%0d rd=%0d", obs_n, obs_wr_seen, obs_rd_seen);
        checks++;
        if (!(obs_wr_seen && !obs_rd_seen)) begin errors++; $display("FAIL both_req_dir: got rd=%0d wr=%0d expected 0/1", obs_rd_seen, obs_wr_seen); end
        checks++;
        if (obs_ad_data !== exp_ad_data) begin errors++; $display("FAIL both_req_data: got %h expected %h", obs_ad_data, exp_ad_data); end
        checks++;
        if (obs_done_cnt !== 1 || obs_n !== exp_n || obs_pulse_after !== 1'b0) begin
            errors++; $display("FAIL both_req_pulse: got done=%0d n=%0d after=%0d expected 1/%0d/0", obs_done_cnt, obs_n, obs_pulse_after, exp_n);
        end
        checks++;
        if (obs_freeze_bad !== 1'b0) begin errors++; $display("FAIL both_req_freeze: got output change with ce=0 expected none"); end
        checks++;
        if (rdata !== rdata_model) begin errors++; $display("FAIL both_req_rdata: got %h expected %h", rdata, rdata_model); end
    endtask

    task automatic test_back_to_back();
        model_txn(1'b0, 1'b0, 16'o000200, 16'h0000, 16'h1357, 1);
        run_txn(1'b1, 1'b0, 1'b0, 16'o000200, 16'h0000, 16'h1357, 1, 1'b0, 1'b0, 1'b1);
        $display("txn back_to_back n=%0d busy_after=%0d sync_after2=%0d", obs_n, obs_busy_after, obs_sync_after2);
        checks++;
        if (obs_done_cnt !== 1 || obs_n !== exp_n) begin errors++; $display("FAIL b2b_done: got done=%0d n=%0d expected 1/%0d", obs_done_cnt, obs_n, exp_n); end
        checks++;
        if (obs_busy_after !== 1'b0 || obs_sync_after !== 1'b0) begin
            errors++; $display("FAIL b2b_ignore_in_done: got busy=%0d sync=%0d expected 0/0", obs_busy_after, obs_sync_after);
        end
        checks++;
        if (obs_sync_after2 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got sync=%0d expected 1", obs_sync_after2); end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        int guard;
        bit bad_pulse;
        guard = 0; bad_pulse = 0;
        ce = 1'b1; rd_req = 1'b1; byte_op = 1'b0; addr = 16'o000400;
        bus_if.bus_rply = 1'b0;
        while (!bus_if.bus_rd && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (bus_if.bus_rd !== 1'b1) begin errors++; $display("FAIL reset_mid_reach_data: got bus_rd=%b expected 1", bus_if.bus_rd); end
        #2 reset = 1'b1;
        #1;
        $display("txn reset_mid");
        checks++;
        if ({bus_if.bus_sync, bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_wtbt, busy} !== 5'b00000) begin
            errors++; $display("FAIL reset_mid_strobes: got %b expected 00000",
                               {bus_if.bus_sync, bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_wtbt, busy});
        end
        rd_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        rdata_model = 16'h0000;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || bus_err) bad_pulse = 1;
        end
        checks++;
        if (bad_pulse) begin errors++; $display("FAIL reset_mid_no_pulse: got done or bus_err after reset expected none"); end
        checks++;
        if (rdata !== rdata_model) begin errors++; $display("FAIL reset_mid_rdata: got %h expected %h", rdata, rdata_model); end
    endtask

    task automatic test_random();
        logic        t_rd, t_wr, t_byte;
        logic [15:0] t_addr, t_wdata, t_din;
        int          kind, sel, t_reply;
        bit          rce;
        for (int i = 0; i < 40; i++) begin
            kind    = $urandom_range(0, 2);
            t_rd    = (kind != 1);
            t_wr    = (kind != 0);
            t_byte  = 1'($urandom);
            t_addr  = 16'($urandom);
            t_wdata = 16'($urandom);
            t_din   = 16'($urandom);
            sel     = $urandom_range(0, 9);
            if (sel < 7)       t_reply = $urandom_range(0, 6);
            else if (sel == 7) t_reply = TIMEOUT - 1;
            else if (sel == 8) t_reply = TIMEOUT;
            else               t_reply = -1;
            rce = 1'($urandom);
            model_txn(t_wr, t_byte, t_addr, t_wdata, t_din, t_reply);
            run_txn(t_rd, t_wr, t_byte, t_addr, t_wdata, t_din, t_reply, rce, 1'b1, 1'b0);
            $display("txn rand %0d: rd=%0d wr=%0d byte=%0d addr=%h reply=%0d ce_rand=%0d n=%0d done=%0d err=%0d rdata=%h",
                     i, t_rd, t_wr, t_byte, t_addr, t_reply, rce, obs_n, obs_done_cnt, obs_err_cnt, rdata);
            checks++;
            if (obs_hung || obs_done_cnt !== int'(exp_ok) || obs_err_cnt !== int'(!exp_ok)) begin
                errors++; $display("FAIL rand_outcome[%0d]: got done=%0d err=%0d hung=%0d expected done=%0d", i, obs_done_cnt, obs_err_cnt, obs_hung, exp_ok);
            end
            checks++;
            if (obs_n !== exp_n) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, obs_n, exp_n); end
            checks++;
            if (rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rdata, exp_rdata); end
            checks++;
            if (obs_sync_seen !== exp_sync) begin errors++; $display("FAIL rand_sync[%0d]: got %0d expected %0d", i, obs_sync_seen, exp_sync); end
            if (exp_sync) begin
                checks++;
                if (obs_ad_addr !== exp_ad_addr || obs_wtbt_addr !== exp_wtbt_a || obs_wtbt_data !== exp_wtbt_d) begin
                    errors++; $display("FAIL rand_addr_phase[%0d]: got ad=%h wtbt=%b/%b expected ad=%h wtbt=%b/%b",
                                       i, obs_ad_addr, obs_wtbt_addr, obs_wtbt_data, exp_ad_addr, exp_wtbt_a, exp_wtbt_d);
                end
                checks++;
                if (obs_wr_seen !== t_wr || obs_rd_seen !== !t_wr) begin
                    errors++; $display("FAIL rand_dir[%0d]: got rd=%0d wr=%0d expected wr=%0d", i, obs_rd_seen, obs_wr_seen, t_wr);
                end
                if (t_wr) begin
                    checks++;
                    if (obs_ad_data !== exp_ad_data) begin errors++; $display("FAIL rand_wdata[%0d]: got %h expected %h", i, obs_ad_data, exp_ad_data); end
                end
            end
            checks++;
            if (obs_pulse_after !== 1'b0 || obs_ad_after !== 16'h0000 || obs_freeze_bad !== 1'b0) begin
                errors++; $display("FAIL rand_idle[%0d]: got pulse=%0d ad=%h freeze_bad=%0d expected 0/0000/0",
                                   i, obs_pulse_after, obs_ad_after, obs_freeze_bad);
            end
            rdata_model = exp_rdata;
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_odd_addr();
        test_timeout();
        test_both_req_ce();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63: number of ce-qualified cycles to wait for bus_rply before aborting.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port ce, input, 1: clock enable; state, counter and registered outputs advance only when ce=1.
REQ-005 SHALL have port rd_req, input, 1: read request from the CPU control unit; sampled in IDLE.
REQ-006 SHALL have port wr_req, input, 1: write request; sampled in IDLE.
REQ-007 SHALL have port byte_op, input, 1: 1 = byte access, 0 = word access.
REQ-008 SHALL have port addr, input, 16: CPU address (datapath dba).
REQ-009 SHALL have port wdata, input, 16: CPU write data (datapath dbo).
REQ-010 SHALL have port rdata, output, 16: registered read data, fed to datapath dbi.
REQ-011 SHALL have port done, output, 1: one-ce-cycle pulse on successful completion.
REQ-012 SHALL have port bus_err, output, 1: one-ce-cycle pulse on timeout or odd-address error.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port bus_ad, output, 16: external address/data out.
REQ-015 SHALL have port bus_din, input, 16: external read data.
REQ-016 SHALL have port bus_sync, output, 1: address strobe.
REQ-017 SHALL have port bus_rd, output, 1: read data strobe.
REQ-018 SHALL have port bus_wr, output, 1: write data strobe.
REQ-019 SHALL have port bus_wtbt, output, 1: byte-cycle indicator.
REQ-020 SHALL have port bus_rply, input, 1: slave reply, synchronous to clk.

Function
REQ-021 SHALL implement states IDLE, ADDR, DATA, RELEASE, ERR.
REQ-022 IDLE: if rd_req or wr_req, SHALL latch addr, wdata, byte_op and the direction; wr_req SHALL win when both are high.
REQ-023 IDLE: word access with addr[0]=1 SHALL go to ERR without asserting any bus strobe.
REQ-024 IDLE, otherwise: SHALL go to ADDR and clear the timeout counter.
REQ-025 ADDR (1 ce cycle): bus_ad = latched address; bus_sync=1; bus_wtbt = write OR byte_op; next state DATA.
REQ-026 DATA, write: bus_ad SHALL equal wdata for a word access, or {wdata[7:0], wdata[7:0]} for a byte access.
REQ-027 DATA: bus_sync SHALL stay 1 and bus_rd or bus_wr SHALL be 1 per direction; bus_wtbt SHALL equal byte_op.
REQ-028 DATA: on bus_rply=1, a read SHALL latch rdata <= bus_din (full word); next state RELEASE.
REQ-029 DATA: each ce cycle without bus_rply SHALL increment the counter; if the counter equals TIMEOUT, next state ERR.
REQ-030 RELEASE: bus_rd and bus_wr SHALL be 0 and bus_sync=1; stay until bus_rply=0, then pulse done and go to IDLE.
REQ-031 ERR: all strobes SHALL be 0; pulse bus_err for one ce cycle; go to IDLE; rdata SHALL be unchanged.
REQ-032 Requests arriving while busy=1 SHALL be ignored; the requester holds its request until done or bus_err.
REQ-033 The earliest new request SHALL be accepted in the ce cycle after a done or bus_err pulse.
REQ-034 Minimum transaction with immediate reply: IDLE->ADDR->DATA->RELEASE->IDLE, with done asserted in the 4th ce cycle after acceptance.
REQ-035 ce=0 SHALL freeze all state, the counter and outputs; done and bus_err pulses SHALL last exactly one ce-qualified cycle.
REQ-036 The timeout counter SHALL be wide enough for TIMEOUT with no wrap-around; a bus_rply in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-037 bus_ad SHALL be 0 in IDLE and ERR.

Reset
REQ-038 reset=1 SHALL asynchronously force IDLE, counter=0, rdata=0, done=0, bus_err=0, busy=0, bus_sync=bus_rd=bus_wr=bus_wtbt=0 and bus_ad=0.
REQ-039 Reset mid-transaction SHALL abort immediately with all strobes deasserted; no done or bus_err pulse SHALL follow.

Verification
REQ-040 Word read at addr 0o177660, slave replies 2 cycles after bus_rd with 0o123456 -> rdata=0o123456, done pulse, bus_wtbt=0 throughout.
REQ-041 Byte write at addr 0o001001 with wdata=0o000252 -> bus_ad shows 0o001001 in ADDR and 0x AAAA in DATA, bus_wtbt=1, done pulse.
REQ-042 Word write at addr 0o001001 -> bus_err pulse within 2 ce cycles, bus_sync never asserted.
REQ-043 Read with bus_rply held low, TIMEOUT=63 -> bus_err exactly 63 ce cycles after DATA entry, strobes low, rdata unchanged.
REQ-044 rd_req and wr_req both high, with ce toggling 1-0-1 -> write cycle performed, pulses last one ce cycle; reset asserted in DATA -> strobes low at once and no done.
